memory_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one block memory (`width`-bit, `blocks` cells per access, registered 1-cycle read) between `requesters` independent clients of the coprocessor: load/store units and the matrix engine. It accepts one valid/ready request per cycle and issues registered commands to the memory. It range-checks every address and returns a tagged response (read data or write acknowledge) to the originating client at a fixed latency. It sits between the client ports and the memory instance and is the only driver of the memory's address, data and enable inputs.

---
 rtl/memory_arbiter.sv | 159 +++++++++++++++
 tb/tb_memory_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter/sequencer sharing one block memory between several clients.
// Grants one request per cycle, issues registered memory commands, returns tagged responses two cycles later.
module memory_arbiter #(
  parameter int requesters = 2,
  parameter int size       = 1024,
  parameter int log_size   = 10,
  parameter int blocks     = 4,
  parameter int cell_width = 32,
  parameter int width      = blocks * cell_width
) (
  input  logic                           in_clk,
  input  logic                           in_reset,
  input  logic [requesters-1:0]          in_req_valid,
  input  logic [requesters-1:0]          in_req_write,
  input  logic [requesters*log_size-1:0] in_req_address,
  input  logic [requesters*width-1:0]    in_req_data,
  output logic [requesters-1:0]          out_req_ready,
  output logic [requesters-1:0]          out_resp_valid,
  output logic                           out_resp_error,
  output logic [width-1:0]               out_resp_data,
  output logic [log_size-1:0]            out_mem_address,
  output logic [width-1:0]               out_mem_data,
  output logic                           out_mem_read_en,
  output logic                           out_mem_write_en,
  input  logic [width-1:0]               in_mem_data
);

  localparam int id_w = (requesters > 1) ? $clog2(requesters) : 1;
  localparam logic [log_size:0] blocks_ext = (log_size + 1)'(blocks);
  localparam logic [log_size:0] size_ext   = (log_size + 1)'(size);

  logic [id_w-1:0]     prio_r;
  logic [id_w-1:0]     grant_id_s;
  logic                grant_hit_s;
  logic                take_s;
  int                  idx_s;
  logic [id_w-1:0]     next_prio_s;
  logic [log_size-1:0] sel_address_s;
  logic [width-1:0]    sel_data_s;
  logic                sel_write_s;
  logic                sel_in_range_s;

  // Issue stage: command to memory plus the tag that follows it
  logic                iss_valid_r;
  logic [id_w-1:0]     iss_id_r;
  logic                iss_write_r;
  logic                iss_error_r;
  logic [log_size-1:0] mem_address_r;
  logic [width-1:0]    mem_data_r;
  logic                mem_read_en_r;
  logic                mem_write_en_r;

  // Middle stage: tag aligned with the memory's registered read data
  logic                mid_valid_r;
  logic [id_w-1:0]     mid_id_r;
  logic                mid_error_r;
  logic                mid_read_ok_r;

  logic [requesters-1:0] resp_valid_r;
  logic                  resp_error_r;
  logic [width-1:0]      resp_data_r;

  // Round-robin search starting at prio
  always_comb begin
    grant_hit_s = 1'b0;
    grant_id_s  = '0;
    take_s      = 1'b0;
    idx_s       = 0;
    for (int i = 0; i < requesters; i++) begin
      idx_s       = (int'(prio_r) + i) % requesters;
      take_s      = !grant_hit_s && in_req_valid[id_w'(idx_s)];
      grant_id_s  = take_s ? id_w'(idx_s) : grant_id_s;
      grant_hit_s = grant_hit_s | take_s;
    end
  end

  // Grant is combinational and forced low while reset is held
  always_comb begin
    out_req_ready = '0;
    if (in_reset && grant_hit_s) begin
      out_req_ready[grant_id_s] = 1'b1;
    end else begin
      out_req_ready = '0;
    end
  end

  assign sel_address_s  = in_req_address[int'(grant_id_s)*log_size +: log_size];
  assign sel_data_s     = in_req_data[int'(grant_id_s)*width +: width];
  assign sel_write_s    = in_req_write[grant_id_s];
  assign sel_in_range_s = ({1'b0, sel_address_s} + blocks_ext) <= size_ext;
  assign next_prio_s    = (int'(grant_id_s) == requesters - 1) ? '0 : grant_id_s + 1'b1;

  // Pointer update and issue stage; out-of-range requests leave memory untouched
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      prio_r         <= '0;
      iss_valid_r    <= 1'b0;
      iss_id_r       <= '0;
      iss_write_r    <= 1'b0;
      iss_error_r    <= 1'b0;
      mem_address_r  <= '0;
      mem_data_r     <= '0;
      mem_read_en_r  <= 1'b0;
      mem_write_en_r <= 1'b0;
    end else if (grant_hit_s) begin
      prio_r      <= next_prio_s;
      iss_valid_r <= 1'b1;
      iss_id_r    <= grant_id_s;
      iss_write_r <= sel_write_s;
      iss_error_r <= !sel_in_range_s;
      if (sel_in_range_s) begin
        mem_address_r  <= sel_address_s;
        mem_data_r     <= sel_data_s;
        mem_read_en_r  <= !sel_write_s;
        mem_write_en_r <= sel_write_s;
      end else begin
        mem_read_en_r  <= 1'b0;
        mem_write_en_r <= 1'b0;
      end
    end else begin
      iss_valid_r    <= 1'b0;
      mem_read_en_r  <= 1'b0;
      mem_write_en_r <= 1'b0;
    end
  end

  // Tag waits one cycle for the memory read, then the response is registered
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      mid_valid_r   <= 1'b0;
      mid_id_r      <= '0;
      mid_error_r   <= 1'b0;
      mid_read_ok_r <= 1'b0;
      resp_valid_r  <= '0;
      resp_error_r  <= 1'b0;
      resp_data_r   <= '0;
    end else begin
      mid_valid_r   <= iss_valid_r;
      mid_id_r      <= iss_id_r;
      mid_error_r   <= iss_valid_r && iss_error_r;
      mid_read_ok_r <= iss_valid_r && !iss_write_r && !iss_error_r;
      resp_valid_r  <= '0;
      if (mid_valid_r) begin
        resp_valid_r[mid_id_r] <= 1'b1;
      end
      resp_error_r <= mid_valid_r && mid_error_r;
      resp_data_r  <= mid_read_ok_r ? in_mem_data : '0;
    end
  end

  assign out_mem_address  = mem_address_r;
  assign out_mem_data     = mem_data_r;
  assign out_mem_read_en  = mem_read_en_r;
  assign out_mem_write_en = mem_write_en_r;
  assign out_resp_valid   = resp_valid_r;
  assign out_resp_error   = resp_error_r;
  assign out_resp_data    = resp_data_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level model checked every cycle, plus directed literal checks.
module tb_memory_arbiter;
  localparam int NREQ = 2;
  localparam int SIZE = 1024;
  localparam int BLK  = 4;
  localparam int W    = 128;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    v = '0;
  logic [NREQ-1:0]    wr = '0;
  logic [NREQ*10-1:0] addr = '0;
  logic [NREQ*W-1:0]  data = '0;
  logic [NREQ-1:0]    ready, resp_valid;
  logic               resp_error, mem_re, mem_we;
  logic [W-1:0]       resp_data, mem_wdata, mem_rdata;
  logic [9:0]         mem_addr;

  logic [3:0]   v4 = '0;
  logic [3:0]   ready4, resp_valid4;
  logic         resp_error4, mem_re4, mem_we4;
  logic [W-1:0] resp_data4, mem_wdata4;
  logic [W-1:0] zero4 = '0;
  logic [9:0]   mem_addr4;

  memory_arbiter #(.requesters(2)) dut (
    .in_clk(clk), .in_reset(rst), .in_req_valid(v), .in_req_write(wr),
    .in_req_address(addr), .in_req_data(data), .out_req_ready(ready),
    .out_resp_valid(resp_valid), .out_resp_error(resp_error), .out_resp_data(resp_data),
    .out_mem_address(mem_addr), .out_mem_data(mem_wdata), .out_mem_read_en(mem_re),
    .out_mem_write_en(mem_we), .in_mem_data(mem_rdata));

  memory_arbiter #(.requesters(4)) dut4 (
    .in_clk(clk), .in_reset(rst), .in_req_valid(v4), .in_req_write(4'b0000),
    .in_req_address(40'd0), .in_req_data(512'd0), .out_req_ready(ready4),
    .out_resp_valid(resp_valid4), .out_resp_error(resp_error4), .out_resp_data(resp_data4),
    .out_mem_address(mem_addr4), .out_mem_data(mem_wdata4), .out_mem_read_en(mem_re4),
    .out_mem_write_en(mem_we4), .in_mem_data(zero4));

  // Block memory attached to the main instance: registered one-cycle read
  logic [31:0] ram [SIZE];
  initial for (int i = 0; i < SIZE; i++) ram[i] = 32'd0;
  always @(posedge clk) begin
    if (mem_we) for (int j = 0; j < BLK; j++) ram[int'(mem_addr) + j] <= mem_wdata[j*32 +: 32];
    if (mem_re) for (int j = 0; j < BLK; j++) mem_rdata[j*32 +: 32] <= ram[int'(mem_addr) + j];
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Transaction-level model: what each handshake must produce
  typedef struct {
    int         due;
    int         id;
    logic       err;
    logic [W-1:0] rdata;
  } resp_t;

  resp_t        exp_q[$];
  logic [31:0]  gm [SIZE];
  int           m_prio = 0;
  int           cyc = 0;
  logic         em_rd = 1'b0, em_wr = 1'b0;
  logic [9:0]   em_addr = '0;
  logic [W-1:0] em_data = '0;
  initial for (int i = 0; i < SIZE; i++) gm[i] = 32'd0;

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] vv);
    for (int i = 0; i < NREQ; i++) begin
      if (vv[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prio = 0;
      exp_q.delete();
      em_rd = 1'b0; em_wr = 1'b0; em_addr = '0; em_data = '0;
    end else begin
      int g, a;
      resp_t r;
      cyc++;
      g = rr_pick(m_prio, v);
      em_rd = 1'b0;
      em_wr = 1'b0;
      if (g >= 0) begin
        a = int'(addr[g*10 +: 10]);
        r.due = cyc + 2;
        r.id = g;
        r.err = !(a + BLK <= SIZE);
        r.rdata = '0;
        if (!r.err) begin
          em_addr = addr[g*10 +: 10];
          em_data = data[g*W +: W];
          em_rd = !wr[g];
          em_wr = wr[g];
          for (int j = 0; j < BLK; j++) begin
            if (wr[g]) gm[a + j] = data[g*W + j*32 +: 32];
            else r.rdata[j*32 +: 32] = gm[a + j];
          end
        end
        exp_q.push_back(r);
        m_prio = (g + 1) % NREQ;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [NREQ-1:0] e_ready, e_rv;
    logic e_err;
    logic [W-1:0] e_data;
    int g;
    e_ready = '0; e_rv = '0; e_err = 1'b0; e_data = '0;
    g = rr_pick(m_prio, v);
    if (rst && g >= 0) e_ready[g] = 1'b1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_rv[exp_q[0].id] = 1'b1;
      e_err = exp_q[0].err;
      e_data = exp_q[0].rdata;
      void'(exp_q.pop_front());
    end
    chk("m_ready", W'(ready), W'(e_ready));
    chk("m_resp_valid", W'(resp_valid), W'(e_rv));
    chk("m_resp_error", W'(resp_error), W'(e_err));
    chk("m_resp_data", resp_data, e_data);
    chk("m_mem_read_en", W'(mem_re), W'(em_rd));
    chk("m_mem_write_en", W'(mem_we), W'(em_wr));
    if (!rst || em_rd || em_wr) begin
      chk("m_mem_address", W'(mem_addr), W'(em_addr));
      chk("m_mem_data", mem_wdata, em_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int k, input logic w, input logic [9:0] a, input logic [W-1:0] d);
    v[k] = 1'b1;
    wr[k] = w;
    addr[k*10 +: 10] = a;
    data[k*W +: W] = d;
  endtask

  logic [W-1:0] d1 = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [W-1:0] dd = {4{32'hDEAD_BEEF}};
  logic [W-1:0] d3 = {32'hA0A0_0003, 32'hB0B0_0002, 32'hC0C0_0001, 32'hD0D0_0000};
  logic [W-1:0] d4 = {4{32'h5555_AAAA}};
  logic [1:0] exp_c [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [3:0] exp_f [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    v = 2'b11;
    #1;
    chk("reset_ready", W'(ready), W'(2'b00));
    chk("reset_resp_valid", W'(resp_valid), W'(2'b00));
    chk("reset_mem_address", W'(mem_addr), W'(10'h000));
    v = '0;
    rst = 1'b1;

    // Write then read at 0x008 from client 0
    set_req(0, 1'b1, 10'h008, d1);
    step();
    set_req(0, 1'b0, 10'h008, '0);
    step();
    v[0] = 1'b0;
    step();
    chk("t1_wr_resp_valid", W'(resp_valid), W'(2'b01));
    chk("t1_wr_resp_data", resp_data, '0);
    chk("t1_wr_resp_error", W'(resp_error), W'(1'b0));
    step();
    chk("t1_rd_resp_valid", W'(resp_valid), W'(2'b01));
    chk("t1_rd_resp_data", resp_data, d1);

    // Back-to-back read-after-write across clients
    set_req(0, 1'b1, 10'h010, dd);
    step();
    v[0] = 1'b0;
    set_req(1, 1'b0, 10'h010, '0);
    step();
    v[1] = 1'b0;
    step();
    chk("raw_wr_resp_valid", W'(resp_valid), W'(2'b01));
    step();
    chk("raw_rd_resp_valid", W'(resp_valid), W'(2'b10));
    chk("raw_rd_resp_data", resp_data, dd);

    // Contention: both clients valid for six cycles
    set_req(0, 1'b0, 10'h020, '0);
    set_req(1, 1'b0, 10'h040, '0);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("contention_grant", W'(ready), W'(exp_c[i]));
      step();
    end
    v = '0;
    repeat (2) step();

    // Range boundary at the top of memory
    set_req(0, 1'b1, 10'h3FC, d3);
    step();
    set_req(0, 1'b1, 10'h3FD, d4);
    #1;
    chk("bnd_inrange_we", W'(mem_we), W'(1'b1));
    step();
    #1;
    chk("bnd_oob_we", W'(mem_we), W'(1'b0));
    chk("bnd_oob_re", W'(mem_re), W'(1'b0));
    set_req(0, 1'b0, 10'h3FC, '0);
    step();
    v[0] = 1'b0;
    chk("bnd_inrange_error", W'(resp_error), W'(1'b0));
    step();
    chk("bnd_oob_resp_valid", W'(resp_valid), W'(2'b01));
    chk("bnd_oob_error", W'(resp_error), W'(1'b1));
    step();
    chk("bnd_readback", resp_data, d3);
    repeat (2) step();

    // Reset while a read is in flight
    set_req(0, 1'b0, 10'h008, '0);
    step();
    v = '0;
    step();
    rst = 1'b0;
    v = 2'b11;
    #1;
    chk("midrst_ready", W'(ready), W'(2'b00));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_resp_valid", W'(resp_valid), W'(2'b00));
      chk("midrst_mem_re", W'(mem_re), W'(1'b0));
    end
    rst = 1'b1;
    #1;
    chk("post_reset_grant", W'(ready), W'(2'b01));
    step();
    v = '0;
    repeat (4) step();

    // Fairness with four clients, only 1 and 3 active
    v4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fair4_grant", W'(ready4), W'(exp_f[i]));
      step();
    end
    v4 = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
